// File: rtl/tmds_channel_encoder.sv
// Three-channel DVI TMDS 8b/10b encoder, two-stage pipeline in the pixel clock domain.
// Stage 1 registers the transition-minimised word; stage 2 applies DC balance per channel.
module tmds_channel_encoder #(
    parameter bit         CTRL_BLUE_ONLY = 1'b1,
    parameter logic [9:0] RESET_WORD     = 10'b1101010100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] rgb,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        vde,
    input  logic [3:0]  ctl,
    output logic [9:0]  tmds_ch0,
    output logic [9:0]  tmds_ch1,
    output logic [9:0]  tmds_ch2
);

    function automatic logic [3:0] count_ones(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
        return n;
    endfunction

    function automatic logic [8:0] min_transitions(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = count_ones(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = 9'd0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] w;
        case (c)
            2'b00:   w = 10'b1101010100;
            2'b01:   w = 10'b0010101011;
            2'b10:   w = 10'b0101010100;
            default: w = 10'b1010101011;
        endcase
        return w;
    endfunction

    logic       vde_d;
    logic [1:0] ctrl_in [3];
    logic [9:0] word    [3];

    // ch0 always carries the syncs; ch1/ch2 carry ctl only in HDMI-style control mode.
    always_comb begin
        ctrl_in[0] = {vsync, hsync};
        ctrl_in[1] = CTRL_BLUE_ONLY ? 2'b00 : ctl[1:0];
        ctrl_in[2] = CTRL_BLUE_ONLY ? 2'b00 : ctl[3:2];
    end

    always_ff @(posedge clk) begin
        if (!reset) vde_d <= 1'b0;
        else        vde_d <= vde;
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        logic [8:0]        q_m;
        logic [1:0]        ctrl_d;
        logic signed [4:0] cnt;
        logic [9:0]        word_nx;
        logic signed [4:0] cnt_nx;
        logic [3:0]        n1q;
        logic signed [5:0] diff6;
        logic signed [4:0] diff;

        always_ff @(posedge clk) begin
            if (!reset) begin
                q_m    <= 9'd0;
                ctrl_d <= 2'b00;
            end else begin
                q_m    <= min_transitions(rgb[ch*8 +: 8]);
                ctrl_d <= ctrl_in[ch];
            end
        end

        // diff = N1q - N0q = 2*N1q - 8, always within -8..+8
        always_comb begin
            n1q   = count_ones(q_m[7:0]);
            diff6 = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
            diff  = diff6[4:0];
        end

        always_comb begin
            word_nx = ctrl_code(ctrl_d);
            cnt_nx  = 5'sd0;
            if (vde_d) begin
                if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
                    word_nx = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
                    cnt_nx  = q_m[8] ? (cnt + diff) : (cnt - diff);
                end else if (((cnt > 5'sd0) && (diff > 5'sd0)) ||
                             ((cnt < 5'sd0) && (diff < 5'sd0))) begin
                    word_nx = {1'b1, q_m[8], ~q_m[7:0]};
                    cnt_nx  = cnt + (q_m[8] ? 5'sd2 : 5'sd0) - diff;
                end else begin
                    word_nx = {1'b0, q_m[8], q_m[7:0]};
                    cnt_nx  = cnt + diff - (q_m[8] ? 5'sd0 : 5'sd2);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                cnt  <= 5'sd0;
                word[ch] <= RESET_WORD;
            end else begin
                cnt  <= cnt_nx;
                word[ch] <= word_nx;
            end
        end
    end

    assign tmds_ch0 = word[0];
    assign tmds_ch1 = word[1];
    assign tmds_ch2 = word[2];

endmodule

// File: doc/tmds_channel_encoder.md
Name: tmds_channel_encoder

Overview:
- Downstream stage of the game top-levels: consumes the 24-bit rgb, hsync, vsync and vde outputs of the racing game and produces three 10-bit TMDS words (blue/ch0, green/ch1, red/ch2) for the HDMI serializer.
- Implements DVI 1.0 8b/10b TMDS encoding, with per-channel running-disparity tracking, in a 2-stage pipeline.
- Runs in the pixel clock domain; the serializer runs at 10x this clock.

Parameters:
- CTRL_BLUE_ONLY, 1, 1 = hsync/vsync carried on ch0 only and ch1/ch2 control bits forced to 00 (DVI mode); 0 = ch1/ch2 control bits taken from ctl[3:0].
- RESET_WORD, 10'b1101010100, TMDS word driven on all channels while reset is asserted (this is the control code for c1c0 = 00).

Ports:
- clk, input, 1: pixel clock.
- reset, input, 1: synchronous, active-low reset.
- rgb, input, 24: pixel data {red[23:16], green[15:8], blue[7:0]}.
- hsync, input, 1: horizontal sync (ch0 c0).
- vsync, input, 1: vertical sync (ch0 c1).
- vde, input, 1: video data enable; 1 = active pixel.
- ctl, input, 4: {ch2 c1, ch2 c0, ch1 c1, ch1 c0}. Used only when CTRL_BLUE_ONLY = 0.
- tmds_ch0, output, 10: encoded blue/sync word.
- tmds_ch1, output, 10: encoded green word.
- tmds_ch2, output, 10: encoded red word.

Behaviour:
- Reset: one clk edge with reset = 0 does the following.
  - All tmds_chN are set to RESET_WORD.
  - All disparity counters are cleared to 0.
  - Pipeline registers are cleared (vde_d = 0, sync = 0).
  - Reset takes effect mid-frame with no draining; the first valid word appears 2 cycles after reset is released.
- Latency: exactly 2 clk cycles from inputs to tmds_chN. vde and control bits are pipelined with the data so they stay aligned.
- Stage 1 (transition minimisation), per channel with data D[7:0]:
  - N1 = popcount(D).
  - If N1 > 4, or N1 == 4 with D[0] == 0: q_m[0] = D[0], q_m[i] = q_m[i-1] XNOR D[i], q_m[8] = 0.
  - Otherwise: the same chain with XOR, and q_m[8] = 1.
  - q_m[8:0], vde and the control bits are registered.
- Stage 2 (DC balance):
  - Per channel, cnt is a 5-bit signed register with range -8..+8. N1q and N0q are the ones and zeros counts of q_m[7:0].
  - Case vde_d = 0: output the control code and set cnt to 0.
    - c1c0 = 00 -> 1101010100
    - c1c0 = 01 -> 0010101011
    - c1c0 = 10 -> 0101010100
    - c1c0 = 11 -> 1010101011
  - Case cnt == 0 or N1q == N0q:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (N1q - N0q) : (N0q - N1q).
  - Case (cnt > 0 and N1q > N0q) or (cnt < 0 and N0q > N1q):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (N0q - N1q).
  - Otherwise:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += (N1q - N0q) - 2*(~q_m[8]).
  - All arithmetic is sign-extended to 5 bits. cnt never leaves -8..+8 for legal sequences; no saturation logic is required.
- Channel mapping:
  - ch0 uses c1 = vsync, c0 = hsync.
  - ch1 and ch2 use 00 when CTRL_BLUE_ONLY = 1, otherwise ctl.
- Behaviour on the vde edge:
  - vde falling: the control code appears on the first blank cycle, and cnt resets in that same cycle.
  - vde rising: data encoding starts with cnt = 0.
  - hsync/vsync toggling while vde = 1 is ignored in the output; only its pipelined value at blanking matters.
- Channels are fully independent; identical input bytes on all channels produce identical words.

Test Plan:
- Reset = 0 for 3 cycles with arbitrary inputs -> all channels read 0x354 (1101010100). After release with vde = 0 and hsync = vsync = 0, all channels still read 0x354 two cycles later.
- vde = 0, cycle {vsync,hsync} through 00/01/10/11 -> tmds_ch0 reads 0x354, 0x0AB, 0x154, 0x2AB with 2-cycle latency; ch1 and ch2 stay 0x354.
- vde = 1, rgb = 0x000000 for 3 consecutive pixels from blanking -> each channel reads 0x100, 0x3FF, 0x100, and cnt steps to -8, +2, -6.
- vde = 1, rgb = 0xFFFFFF for one pixel after blanking -> each channel reads 0x200 and cnt = -8. Then vde = 0 -> the control code is output and cnt = 0.
- Random rgb/vde stream for 10k cycles against a reference model -> bit-exact words and |cnt| <= 8. Decoding with a TMDS decoder recovers rgb and sync exactly.
- Reset asserted mid-active-line with cnt != 0 -> the next cycle outputs 0x354. After release, first pixel 0x00 encodes as 0x100, confirming cnt was cleared.
